// File: rtl/uart_rx_buf_ctrl_pkg.sv
// Shared types and helpers for the UART receive-buffer controller.
package uart_buf_pkg;

  localparam int PERR_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } rd_state_e;

  function automatic logic parity_err(input logic [7:0] data, input logic pbit, input logic odd);
    return ((^data) ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_buf_ctrl_if.sv
// Receiver, FIFO and downstream stream signals of the RX buffer controller.
interface uart_rx_buf_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_parity;
  logic       fifo_wr_en;
  logic [8:0] fifo_din;
  logic       fifo_rd_en;
  logic [8:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_ready;

  modport master (
    input  rx_valid, rx_data, rx_parity, fifo_dout, fifo_full, fifo_empty, m_ready,
    output fifo_wr_en, fifo_din, fifo_rd_en, m_valid, m_data, m_perr
  );

  modport slave (
    output rx_valid, rx_data, rx_parity, fifo_dout, fifo_full, fifo_empty, m_ready,
    input  fifo_wr_en, fifo_din, fifo_rd_en, m_valid, m_data, m_perr
  );
endinterface

// File: rtl/uart_rx_buf_ctrl_flow.sv
// Occupancy counter and RTS watermark hysteresis for the RX FIFO.
module rx_flow_ctrl #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 4,
  parameter int HIGH_WM = 6,
  parameter int LOW_WM  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [CNT_W-1:0] level,
  output logic             rts_n
);

  localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HIGH_LVL  = CNT_W'(HIGH_WM);
  localparam logic [CNT_W-1:0] LOW_LVL   = CNT_W'(LOW_WM);

  logic [CNT_W-1:0] level_nxt;

  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en && level != DEPTH_LVL)
      level_nxt = level + 1'b1;
    else if (rd_en && !wr_en && level != '0)
      level_nxt = level - 1'b1;
  end

  // rts_n follows the new level so both registers move on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      rts_n <= 1'b0;
    end else begin
      level <= level_nxt;
      if (level_nxt >= HIGH_LVL)
        rts_n <= 1'b1;
      else if (level_nxt <= LOW_LVL)
        rts_n <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// UART RX buffer controller: parity tagging, FIFO write/drain, flow control, status.
// Parity checking is built only when RX_PARITY_CHECK_EN is defined.
//   state | meaning
//   IDLE  | no byte presented; reads FIFO as soon as it is non-empty
//   VALID | byte from FIFO dout presented on m_data until m_ready
module uart_rx_buf_ctrl
  import uart_buf_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 4,
  parameter int HIGH_WM    = 6,
  parameter int LOW_WM     = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_buf_ctrl_if.master    bus,
  input  logic                  clr_status,
  output logic                  rts_n,
  output logic                  overrun,
  output logic [PERR_CNT_W-1:0] perr_count,
  output logic [CNT_W-1:0]      level
);

  rd_state_e state;
  logic      perr;

`ifdef RX_PARITY_CHECK_EN
  assign perr       = parity_err(bus.rx_data, bus.rx_parity, PARITY_ODD != 0);
  assign bus.m_perr = bus.fifo_dout[8];

  always_ff @(posedge clk) begin
    if (reset || clr_status)
      perr_count <= '0;
    else if (bus.fifo_wr_en && perr && perr_count != '1)
      perr_count <= perr_count + 1'b1;
  end
`else
  logic [1:0] unused_parity_bits;
  assign unused_parity_bits = {bus.rx_parity, bus.fifo_dout[8]};
  assign perr       = 1'b0;
  assign bus.m_perr = 1'b0;
  assign perr_count = '0;
`endif

  // No write-through: a full FIFO drops the frame even if it is being read
  assign bus.fifo_wr_en = bus.rx_valid && !bus.fifo_full;
  assign bus.fifo_din   = {perr, bus.rx_data};
  assign bus.fifo_rd_en = !bus.fifo_empty && (state == IDLE || bus.m_ready);
  assign bus.m_data     = bus.fifo_dout[7:0];

  always_ff @(posedge clk) begin
    if (reset || clr_status)
      overrun <= 1'b0;
    else if (bus.rx_valid && bus.fifo_full)
      overrun <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus.m_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!bus.fifo_empty) begin
          state       <= VALID;
          bus.m_valid <= 1'b1;
        end
        VALID: if (bus.m_ready && bus.fifo_empty) begin
          state       <= IDLE;
          bus.m_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bus.m_valid <= 1'b0;
        end
      endcase
    end
  end

  rx_flow_ctrl #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .HIGH_WM(HIGH_WM),
    .LOW_WM (LOW_WM)
  ) u_flow (
    .clk  (clk),
    .reset(reset),
    .wr_en(bus.fifo_wr_en),
    .rd_en(bus.fifo_rd_en),
    .level(level),
    .rts_n(rts_n)
  );

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Directed bench for uart_rx_buf_ctrl with a behavioural 8-deep FIFO attached.
module tb_uart_rx_buf_ctrl;
  import uart_buf_pkg::*;

`ifdef RX_PARITY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_status;
  logic       rts_n;
  logic       overrun;
  logic [7:0] perr_count;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  uart_rx_buf_ctrl_if bus();

  uart_rx_buf_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_status(clr_status),
    .rts_n     (rts_n),
    .overrun   (overrun),
    .perr_count(perr_count),
    .level     (level)
  );

  always #5 clk = ~clk;

  // behavioural FIFO with registered read data, same reset as the controller
  logic [8:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  assign bus.fifo_full  = (cnt == 4'd8);
  assign bus.fifo_empty = (cnt == 4'd0);

  always @(posedge clk) begin
    if (reset) begin
      wp <= '0; rp <= '0; cnt <= '0; bus.fifo_dout <= '0;
    end else begin
      if (bus.fifo_wr_en) begin mem[wp] <= bus.fifo_din; wp <= wp + 3'd1; end
      if (bus.fifo_rd_en) begin bus.fifo_dout <= mem[rp]; rp <= rp + 3'd1; end
      cnt <= cnt + 4'(bus.fifo_wr_en) - 4'(bus.fifo_rd_en);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset) chk("rd_en_while_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       perr;
  } vec_t;

  vec_t vecs [7];
  int   lvl_after [9];
  logic rts_after [9];

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int exp_cnt;
    logic ep;

    vecs[0] = '{8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 1'b1, 1'b0};
    lvl_after = '{1, 1, 2, 3, 4, 5, 6, 7, 8};
    rts_after = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

    reset = 1'b1; clr_status = 1'b0; bus.m_ready = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_parity = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rts_n", 32'(rts_n), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_perr_count", 32'(perr_count), 0);
    tick();
    reset = 1'b0;

    // single frames, consumer always ready
    bus.m_ready = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      ep = vecs[i].perr & CHK;
      tick();
      bus.rx_valid = 1'b1; bus.rx_data = vecs[i].data; bus.rx_parity = vecs[i].par;
      @(negedge clk);
      chk("vec_wr_en", 32'(bus.fifo_wr_en), 1);
      chk("vec_din", 32'(bus.fifo_din), 32'({ep, vecs[i].data}));
      if (ep) exp_cnt++;
      tick();
      bus.rx_valid = 1'b0;
      @(negedge clk);
      chk("vec_rd_en_n1", 32'(bus.fifo_rd_en), 1);
      chk("vec_m_valid_n1", 32'(bus.m_valid), 0);
      tick();
      @(negedge clk);
      chk("vec_m_valid_n2", 32'(bus.m_valid), 1);
      chk("vec_m_data", 32'(bus.m_data), 32'(vecs[i].data));
      chk("vec_m_perr", 32'(bus.m_perr), 32'(ep));
      chk("vec_perr_count", 32'(perr_count), 32'(exp_cnt));
      chk("vec_level", 32'(level), 0);
      tick();
      @(negedge clk);
      chk("vec_back_idle", 32'(bus.m_valid), 0);
    end

    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    chk("clr_perr_count", 32'(perr_count), 0);

    // fill with consumer stalled: 9 accepted, 10th dropped
    bus.m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.rx_valid = 1'b1; bus.rx_data = 8'(k); bus.rx_parity = ^(8'(k));
      @(negedge clk);
      if (k > 0) begin
        chk("fill_level", 32'(level), 32'(lvl_after[k-1]));
        chk("fill_rts_n", 32'(rts_n), 32'(rts_after[k-1]));
      end
      if (k == 8) chk("ninth_wr_en", 32'(bus.fifo_wr_en), 1);
      if (k == 9) begin
        chk("tenth_wr_en", 32'(bus.fifo_wr_en), 0);
        chk("tenth_overrun_pre", 32'(overrun), 0);
      end
    end
    tick();
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("drop_overrun", 32'(overrun), 1);
    chk("drop_level", 32'(level), 8);
    chk("stall_m_valid", 32'(bus.m_valid), 1);
    chk("stall_m_data", 32'(bus.m_data), 0);

    // drain back to back
    tick();
    bus.m_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("drain_m_valid", 32'(bus.m_valid), 1);
      chk("drain_m_data", 32'(bus.m_data), 32'(j));
      chk("drain_level", 32'(level), 32'(8 - j));
      chk("drain_rts_n", 32'(rts_n), (8 - j > 2) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    chk("drain_idle", 32'(bus.m_valid), 0);
    chk("drain_level_end", 32'(level), 0);
    tick();
    bus.m_ready = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    chk("clr_overrun", 32'(overrun), 0);

    // reset while holding a byte with three more buffered
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.rx_valid = 1'b1; bus.rx_data = 8'(8'h10 + k); bus.rx_parity = ^(8'(8'h10 + k));
    end
    tick();
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_level", 32'(level), 3);
    chk("pre_rst_m_valid", 32'(bus.m_valid), 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_m_valid", 32'(bus.m_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_rts_n", 32'(rts_n), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf_ctrl.md
# uart_rx_buf_ctrl

Controller that sequences the UART receive buffer. It takes received frames from the UART receiver and checks parity. It writes each frame, with its parity-error tag, into the 9-bit RX FIFO, and drains the FIFO to a downstream consumer over a valid/ready stream. It also tracks buffer occupancy, drives hardware flow control (RTS) with watermark hysteresis, and keeps overrun and parity-error status.

## Interface
- DEPTH, 8, FIFO depth in words; must match the attached FIFO.
- CNT_W, 4, occupancy counter width; must hold 0..DEPTH.
- HIGH_WM, 6, level at or above which RTS is deasserted.
- LOW_WM, 2, level at or below which RTS is reasserted; LOW_WM < HIGH_WM.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- rx_valid  in  1  one-cycle pulse: a frame has been received.
- rx_data  in  8  received data byte.
- rx_parity  in  1  received parity bit.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  9  {perr, data} written to the FIFO.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_dout  in  9  FIFO registered read data, valid the cycle after fifo_rd_en.
- fifo_full  in  1  FIFO full.
- fifo_empty  in  1  FIFO empty.
- m_valid  out  1  output byte valid.
- m_data  out  8  output byte.
- m_perr  out  1  output byte had a parity error.
- m_ready  in  1  consumer accepts the byte.
- rts_n  out  1  active-low ready-to-send to the remote transmitter.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- perr_count  out  8  saturating count of parity-error frames.
- level  out  CNT_W  current FIFO occupancy.
- clr_status  in  1  clears overrun and perr_count.

## Operation
- **Write path (combinational):**
  - perr = (^rx_data ^ rx_parity) != PARITY_ODD.
  - fifo_wr_en = rx_valid & !fifo_full; fifo_din = {perr, rx_data}.
  - If rx_valid & fifo_full, the frame is dropped and overrun is set on the next edge.
- **Status:**
  - perr_count increments on every written frame with perr=1 and saturates at 255.
  - Dropped frames do not count toward perr_count.
  - clr_status has priority over a same-cycle set or increment.
- **Read FSM:**
  - IDLE: m_valid=0. If !fifo_empty, fifo_rd_en=1 and the next state is VALID.
  - VALID: m_valid=1, m_data=fifo_dout[7:0], m_perr=fifo_dout[8].
    - On m_ready with !fifo_empty: fifo_rd_en=1, stay in VALID (back-to-back, one byte per cycle).
    - On m_ready with fifo_empty: go to IDLE.
    - Without m_ready: hold; m_data must stay stable.
- **fifo_rd_en** never asserts while fifo_empty=1.
- **Occupancy (level):**
  - +1 on fifo_wr_en, −1 on fifo_rd_en, unchanged when both or neither.
  - Range 0..DEPTH.
  - The byte held in VALID is not counted.
- **Flow control (rts_n):**
  - Set to 1 when level ≥ HIGH_WM.
  - Cleared to 0 when level ≤ LOW_WM.
  - Otherwise holds its value (hysteresis).

## Timing
- Reset values: state IDLE, m_valid=0, fifo_rd_en=0, fifo_wr_en=0 (gated by rx_valid), level=0, rts_n=0, overrun=0, perr_count=0.
- The FIFO shares the same reset; reset mid-transfer discards the held byte and all buffered data.
- Latency: rx_valid at cycle N into an empty FIFO gives fifo_empty=0 at N+1, fifo_rd_en at N+1, and m_valid=1 at N+2.
- rx_valid on the cycle the FIFO is full is dropped even if a read occurs in the same cycle; there is no write-through.
- level, rts_n, overrun and perr_count are registered and update one edge after the causing event.

## Configuration
- RX_PARITY_CHECK_EN defined: parity is computed as above.
- RX_PARITY_CHECK_EN undefined:
  - perr is forced to 0, so fifo_din[8]=0 and m_perr=0.
  - perr_count is tied to 0.
  - rx_parity is ignored.

## Structure
- Shared package uart_buf_pkg holds:
  - the read-FSM state enum (IDLE, VALID);
  - the parity function parity_err(data, pbit, odd);
  - the status counter width constant PERR_CNT_W = 8.
- One sub-module is natural: rx_flow_ctrl, containing the occupancy counter and watermark hysteresis and producing level and rts_n.
- The controller instantiates no FIFO; the FIFO attaches at the next level up.

## Test plan
- Even parity, rx_data=0x55, rx_parity=0 → fifo_din=0x055 written; m_valid=1 two cycles later with m_data=0x55, m_perr=0.
- rx_data=0x01, rx_parity=0, PARITY_ODD=0 → m_perr=1 and perr_count=1. Then clr_status → perr_count=0.
- Write 8 frames with m_ready=0:
  - rts_n rises when level reaches 6;
  - level ends at 7 (one byte is held in VALID);
  - a 9th frame is accepted; a 10th frame sets overrun=1 and is not written.
- Continuing from the filled buffer, hold m_ready=1 → bytes are emitted on consecutive cycles; rts_n falls when level reaches 2; the FSM returns to IDLE when empty.
- Assert reset while in VALID with level=3 → next cycle m_valid=0, level=0, rts_n=0, overrun=0.
- Build without RX_PARITY_CHECK_EN, send a bad-parity frame → m_perr=0 and perr_count=0.
